// File: rtl/ti_share_lut_pipe_if.sv
// Streaming and table-configuration bundle for one TI share lookup pipeline.
// slave: the lookup block. master: whoever feeds it and loads its table.
interface ti_share_lut_pipe_if #(
    parameter int unsigned IN_W  = 8,
    parameter int unsigned OUT_W = 1
);
    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  in_data;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_data;
    logic             cfg_we;
    logic [IN_W-1:0]  cfg_addr;
    logic [OUT_W-1:0] cfg_data;
    logic             cfg_lock;
    logic             locked;

    modport master (
        output in_valid, in_data, out_ready, cfg_we, cfg_addr, cfg_data, cfg_lock,
        input  in_ready, out_valid, out_data, locked
    );

    modport slave (
        input  in_valid, in_data, out_ready, cfg_we, cfg_addr, cfg_data, cfg_lock,
        output in_ready, out_valid, out_data, locked
    );
endinterface

// File: rtl/ti_share_lut_pipe.sv
// Pipelined, runtime-loadable lookup for one coordinate function of a TI S-box share.
// The concatenated input shares address a register table; the entry flows through
// PIPE elastic output stages with valid/ready backpressure. The table can be locked
// against further writes until the next reset.
module ti_share_lut_pipe #(
    parameter int unsigned              IN_W       = 8,
    parameter int unsigned              OUT_W      = 1,
    parameter int unsigned              PIPE       = 2,
    parameter logic [OUT_W*(2**IN_W)-1:0] TABLE_INIT = '0
) (
    input logic                   i_clk,
    input logic                   i_rst_n,
    ti_share_lut_pipe_if.slave    bus
);
    localparam int unsigned Entries = 2 ** IN_W;

    logic [OUT_W-1:0] r_table [Entries];
    logic             r_locked;
    logic [PIPE-1:0]  r_v;
    logic [OUT_W-1:0] r_d [PIPE];

    logic [PIPE-1:0]  w_load;
    logic             w_chain;
    logic [OUT_W-1:0] w_lookup;
    logic             w_accept;

    // Combinational read of the current table; same-edge writes are seen only afterwards.
    assign w_lookup = r_table[bus.in_data];
    assign w_accept = bus.in_valid && w_load[0];

    // Stage k may load when empty or when its content moves on this edge; walks back
    // from out_ready so in_ready never depends on in_valid.
    always_comb begin
        w_load  = '0;
        w_chain = bus.out_ready;
        for (int k = PIPE - 1; k >= 0; k--) begin
            w_chain   = !r_v[k] || w_chain;
            w_load[k] = w_chain;
        end
    end

    // Table storage: reload on reset, otherwise accept writes until locked.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            for (int a = 0; a < Entries; a++) begin
                r_table[a] <= TABLE_INIT[a*OUT_W +: OUT_W];
            end
        end else if (bus.cfg_we && !r_locked) begin
            r_table[bus.cfg_addr] <= bus.cfg_data;
        end
    end

    // One-way lock; a write in the locking cycle still lands since it checks the old value.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_locked <= 1'b0;
        end else if (bus.cfg_lock) begin
            r_locked <= 1'b1;
        end
    end

    // Elastic stage chain; data only moves with a valid item so a stalled output holds.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_v <= '0;
            r_d <= '{default: '0};
        end else begin
            if (w_load[0]) begin
                r_v[0] <= bus.in_valid;
            end
            if (w_accept) begin
                r_d[0] <= w_lookup;
            end
            for (int k = 1; k < PIPE; k++) begin
                if (w_load[k]) begin
                    r_v[k] <= r_v[k-1];
                    if (r_v[k-1]) begin
                        r_d[k] <= r_d[k-1];
                    end
                end
            end
        end
    end

    assign bus.in_ready  = w_load[0];
    assign bus.out_valid = r_v[PIPE-1];
    assign bus.out_data  = r_d[PIPE-1];
    assign bus.locked    = r_locked;

endmodule

// File: tb/tb_ti_share_lut_pipe.sv
// Directed bench for ti_share_lut_pipe: default build (PIPE=2), a PIPE=3 build with an
// all-ones table for reset-flush checks, and a 4-bit identity build with PIPE=1.
module tb_ti_share_lut_pipe;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    ti_share_lut_pipe_if #(.IN_W(8), .OUT_W(1)) if_a ();
    ti_share_lut_pipe_if #(.IN_W(8), .OUT_W(1)) if_b ();
    ti_share_lut_pipe_if #(.IN_W(4), .OUT_W(4)) if_c ();

    ti_share_lut_pipe #(.IN_W(8), .OUT_W(1), .PIPE(2), .TABLE_INIT('0)) u_dut_a (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (if_a)
    );

    ti_share_lut_pipe #(.IN_W(8), .OUT_W(1), .PIPE(3), .TABLE_INIT({256{1'b1}})) u_dut_b (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (if_b)
    );

    ti_share_lut_pipe #(.IN_W(4), .OUT_W(4), .PIPE(1),
                        .TABLE_INIT(64'hFEDC_BA98_7654_3210)) u_dut_c (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (if_c)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled at the falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    logic [0:0] exp_a [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    logic [3:0] sb_q [$];
    logic [3:0] exp_c;

    initial begin
        {if_a.in_valid, if_a.in_data, if_a.out_ready, if_a.cfg_we} = '0;
        {if_a.cfg_addr, if_a.cfg_data, if_a.cfg_lock} = '0;
        {if_b.in_valid, if_b.in_data, if_b.out_ready, if_b.cfg_we} = '0;
        {if_b.cfg_addr, if_b.cfg_data, if_b.cfg_lock} = '0;
        {if_c.in_valid, if_c.in_data, if_c.out_ready, if_c.cfg_we} = '0;
        {if_c.cfg_addr, if_c.cfg_data, if_c.cfg_lock} = '0;

        // Reset and post-reset state
        step();
        step();
        rst_n = 1'b1;
        check("rst_out_valid", 32'(if_a.out_valid), 32'd0);
        check("rst_out_data", 32'(if_a.out_data), 32'd0);
        check("rst_in_ready", 32'(if_a.in_ready), 32'd1);
        check("rst_locked", 32'(if_a.locked), 32'd0);

        // Load entries 4..7 = 0,1,1,0 then stream them back-to-back
        if_a.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if_a.cfg_we   = 1'b1;
            if_a.cfg_addr = 8'(4 + i);
            if_a.cfg_data = exp_a[i];
            step();
        end
        if_a.cfg_we = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if_a.in_valid = 1'b1;
            if_a.in_data  = 8'(4 + i);
            #1;
            check("stream_in_ready", 32'(if_a.in_ready), 32'd1);
            step();
            if (i == 0) begin
                check("stream_latency", 32'(if_a.out_valid), 32'd0);
            end else begin
                check("stream_valid", 32'(if_a.out_valid), 32'd1);
                check("stream_data", 32'(if_a.out_data), 32'(exp_a[i-1]));
            end
        end
        if_a.in_valid = 1'b0;
        step();
        check("stream_last_valid", 32'(if_a.out_valid), 32'd1);
        check("stream_last_data", 32'(if_a.out_data), 32'(exp_a[3]));
        step();
        check("stream_drained", 32'(if_a.out_valid), 32'd0);

        // Backpressure: 5 (->1), 7 (->0) accepted, 6 must wait
        if_a.out_ready = 1'b0;
        if_a.in_valid  = 1'b1;
        if_a.in_data   = 8'd5;
        #1;
        check("bp_ready0", 32'(if_a.in_ready), 32'd1);
        step();
        if_a.in_data = 8'd7;
        #1;
        check("bp_ready1", 32'(if_a.in_ready), 32'd1);
        step();
        if_a.in_data = 8'd6;
        #1;
        check("bp_full", 32'(if_a.in_ready), 32'd0);
        check("bp_hold_valid", 32'(if_a.out_valid), 32'd1);
        check("bp_hold_data", 32'(if_a.out_data), 32'd1);
        step();
        step();
        check("bp_still_full", 32'(if_a.in_ready), 32'd0);
        check("bp_stable_valid", 32'(if_a.out_valid), 32'd1);
        check("bp_stable_data", 32'(if_a.out_data), 32'd1);
        if_a.out_ready = 1'b1;
        #1;
        check("bp_ready_same_cycle", 32'(if_a.in_ready), 32'd1);
        step();
        if_a.in_valid = 1'b0;
        check("bp_drain_2nd", 32'(if_a.out_data), 32'd0);
        check("bp_drain_2nd_v", 32'(if_a.out_valid), 32'd1);
        step();
        check("bp_drain_3rd", 32'(if_a.out_data), 32'd1);
        check("bp_drain_3rd_v", 32'(if_a.out_valid), 32'd1);
        step();
        check("bp_empty", 32'(if_a.out_valid), 32'd0);

        // Read-before-write on entry 9
        if_a.cfg_we   = 1'b1;
        if_a.cfg_addr = 8'd9;
        if_a.cfg_data = 1'b1;
        step();
        if_a.cfg_data = 1'b0;
        if_a.in_valid = 1'b1;
        if_a.in_data  = 8'd9;
        step();
        if_a.cfg_we   = 1'b0;
        if_a.in_valid = 1'b0;
        step();
        check("rbw_old_valid", 32'(if_a.out_valid), 32'd1);
        check("rbw_old_data", 32'(if_a.out_data), 32'd1);
        if_a.in_valid = 1'b1;
        step();
        if_a.in_valid = 1'b0;
        step();
        check("rbw_new_valid", 32'(if_a.out_valid), 32'd1);
        check("rbw_new_data", 32'(if_a.out_data), 32'd0);
        step();

        // Lock: write in the lock cycle lands (10=1), later write (200=1) ignored
        if_a.cfg_lock = 1'b1;
        if_a.cfg_we   = 1'b1;
        if_a.cfg_addr = 8'd10;
        if_a.cfg_data = 1'b1;
        step();
        if_a.cfg_lock = 1'b0;
        check("lock_set", 32'(if_a.locked), 32'd1);
        if_a.cfg_addr = 8'd200;
        step();
        if_a.cfg_we   = 1'b0;
        if_a.in_valid = 1'b1;
        if_a.in_data  = 8'd200;
        step();
        if_a.in_data = 8'd10;
        step();
        if_a.in_valid = 1'b0;
        check("lock_ignored_v", 32'(if_a.out_valid), 32'd1);
        check("lock_ignored", 32'(if_a.out_data), 32'd0);
        step();
        check("lock_same_cycle_wr", 32'(if_a.out_data), 32'd1);
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("lock_cleared", 32'(if_a.locked), 32'd0);
        if_a.in_valid = 1'b1;
        if_a.in_data  = 8'd10;
        step();
        if_a.in_valid = 1'b0;
        step();
        check("table_reinit_v", 32'(if_a.out_valid), 32'd1);
        check("table_reinit", 32'(if_a.out_data), 32'd0);
        step();

        // PIPE=3 capacity, then reset with three items in flight
        if_b.out_ready = 1'b0;
        if_b.in_valid  = 1'b1;
        if_b.in_data   = 8'd3;
        #1;
        check("b_ready0", 32'(if_b.in_ready), 32'd1);
        step();
        check("b_ready1", 32'(if_b.in_ready), 32'd1);
        step();
        check("b_ready2", 32'(if_b.in_ready), 32'd1);
        step();
        check("b_full", 32'(if_b.in_ready), 32'd0);
        check("b_out_valid", 32'(if_b.out_valid), 32'd1);
        check("b_out_data", 32'(if_b.out_data), 32'd1);
        rst_n = 1'b0;
        if_b.in_valid = 1'b0;
        step();
        rst_n = 1'b1;
        check("b_rst_valid", 32'(if_b.out_valid), 32'd0);
        check("b_rst_data", 32'(if_b.out_data), 32'd0);
        check("b_rst_ready", 32'(if_b.in_ready), 32'd1);
        if_b.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check("b_no_stale", 32'(if_b.out_valid), 32'd0);
        end

        // 4-bit identity table, PIPE=1, random stream with random backpressure
        for (int i = 0; i < 80; i++) begin
            check("c_valid_vs_model", 32'(if_c.out_valid), 32'(sb_q.size() != 0));
            if_c.in_valid  = 1'($urandom_range(1, 0));
            if_c.in_data   = 4'($urandom_range(15, 0));
            if_c.out_ready = 1'($urandom_range(1, 0));
            #1;
            if (if_c.out_valid && if_c.out_ready) begin
                exp_c = sb_q.pop_front();
                check("c_data", 32'(if_c.out_data), 32'(exp_c));
            end
            if (if_c.in_valid && if_c.in_ready) begin
                sb_q.push_back(if_c.in_data);
            end
            step();
        end
        if_c.in_valid  = 1'b0;
        if_c.out_ready = 1'b1;
        if (if_c.out_valid) begin
            exp_c = sb_q.pop_front();
            check("c_tail_data", 32'(if_c.out_data), 32'(exp_c));
        end
        step();
        check("c_drained", 32'(if_c.out_valid), 32'd0);
        check("c_model_empty", 32'(sb_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/ti_share_lut_pipe.md
Name: ti_share_lut_pipe

Overview:
- Parametrised, pipelined evaluator for one component function of a threshold-implementation (TI) S-box share.
- Input is the concatenated input shares. The truth table is held in a runtime-loadable register array instead of a fixed case table.
- Adds a valid/ready streaming handshake with backpressure, configurable pipeline depth and a one-way table lock.
- Sits between share-register stages of the masked S-box datapath. One instance per output coordinate function.

Parameters:
- IN_W, 8, lookup address width (shares × S-box input bits; 8 = 2 shares × 4 bits). Legal range 4..10.
- OUT_W, 1, output bits per table entry. Legal range 1..8.
- PIPE, 2, number of output register stages. Legal range 1..4.
- TABLE_INIT, 0, reset/initial table content, OUT_W×2^IN_W bits. Entry a occupies bits [a×OUT_W +: OUT_W].

Ports:
- clk, input, 1, single clock, rising edge.
- rst_n, input, 1, synchronous active-low reset.
- in_valid, input, 1, in_data is valid.
- in_ready, output, 1, block accepts in_data this cycle.
- in_data, input, IN_W, concatenated shares used as table address.
- out_valid, output, 1, out_data is valid.
- out_ready, input, 1, downstream accepts out_data.
- out_data, output, OUT_W, table entry for the address.
- cfg_we, input, 1, table write strobe.
- cfg_addr, input, IN_W, table write address.
- cfg_data, input, OUT_W, table write data.
- cfg_lock, input, 1, pulse: lock the table against further writes.
- locked, output, 1, table lock status.

Behaviour:
- Reset (rst_n low at a rising edge):
  - Table reloads TABLE_INIT.
  - All stage valid bits clear; locked = 0.
  - out_valid = 0, out_data = 0, in_ready = 1 on the first cycle after reset.
  - A reset mid-stream drops all in-flight items with no output.
- Accept:
  - A transfer occurs when in_valid && in_ready at a rising edge.
  - Lookup is combinational on in_data in the accept cycle. The result is captured into stage 1.
- Pipeline:
  - Stages 1..PIPE, each holding a valid bit and OUT_W data. out_valid/out_data come from stage PIPE.
  - Stage k loads from stage k-1 when stage k is empty or stage k advances in the same cycle.
  - Stage PIPE advances when out_ready is high.
  - Bubbles collapse.
  - in_ready = !v1 || stage1 advances. It is combinational from out_ready through the valid chain, with no combinational path from in_valid.
- Latency and throughput:
  - Accept at edge t gives out_valid at edge t+PIPE-1, visible in the following cycle, when unstalled.
  - Full throughput is one item per cycle.
  - Capacity is PIPE items. With out_ready held low, exactly PIPE items are accepted, then in_ready = 0.
- Output stability:
  - While out_valid && !out_ready, out_data and out_valid hold stable.
  - Data in a stage whose valid bit is low is don't-care. out_data is 0 only after reset.
- Table writes:
  - When cfg_we && !locked at a rising edge, entry cfg_addr ← cfg_data.
  - Read-before-write: a lookup accepted in the same cycle as a write to the same address returns the old entry.
  - Items already in the pipeline are never altered.
- Lock:
  - cfg_lock at a rising edge sets locked = 1. Only reset clears it.
  - If cfg_we and cfg_lock arrive in the same cycle, the write still takes effect (lock applies from the next edge).
  - Writes while locked are silently ignored.
- Ordering: output order equals accept order. No reordering and no drops except on reset.
- Widths: no arithmetic is performed. cfg_addr and in_data use all IN_W bits, so every address is valid.

Test Plan:
- Load and lookup, defaults:
  - Write entries 4 = 0, 5 = 1, 6 = 1, 7 = 0.
  - Stream in_data 4, 5, 6, 7 back-to-back with out_ready = 1.
  - Expect out_data 0, 1, 1, 0, with the first out_valid 2 cycles after the first accept and no gaps.
- Backpressure, PIPE = 2:
  - Hold out_ready = 0 and drive in_valid = 1 continuously.
  - Expect exactly 2 accepts, then in_ready = 0, with out_data stable.
  - Raise out_ready; expect items drained in order and in_ready = 1 in the same cycle.
- Read-before-write:
  - Entry 9 = 1. In one cycle, accept in_data = 9 and write cfg_addr = 9, cfg_data = 0.
  - Expect output 1.
  - A later lookup of 9 returns 0.
- Lock:
  - Pulse cfg_lock; expect locked = 1.
  - Write addr 200 = 1 (previously 0); a lookup of 200 returns 0.
  - Assert rst_n = 0; expect locked = 0 and the table back at TABLE_INIT.
- Reset mid-stream, PIPE = 3:
  - With 3 items in flight and out_ready = 0, assert rst_n for one cycle.
  - Expect out_valid = 0 and out_data = 0 afterwards, in_ready = 1, and no stale item emitted.
- Parameter sweep:
  - IN_W = 4, OUT_W = 4, PIPE = 1, with TABLE_INIT holding the identity mapping.
  - Random stream with random out_ready; expect out_data = in_data in order at 1-cycle latency.
